divisor_match_search: RTL



---
 rtl/dms_pkg.sv | 41 ++++
 rtl/dms_operand_buffer.sv | 24 ++
 rtl/divisor_match_search.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dms_pkg.sv
// Shared types and elaboration helpers for the group-divisor search engine.
package dms_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    INIT,
    CHK,
    EMIT
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Index width; never zero so single-entry ranges still get a 1-bit register.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  // Match counter must hold the value GROUP_SIZE itself.
  function automatic int cnt_w(input int group_size);
    return clog2(group_size + 1);
  endfunction

  function automatic bit params_ok(input int group_size, input int threshold,
                                   input int groups, input int a_width,
                                   input int r_width, input int val_start,
                                   input int val_limit);
    return (group_size >= 1) && (threshold >= 1) && (threshold <= group_size) &&
           (groups >= 1) &&
           (64'(groups) * 64'(group_size) <= (64'd1 << a_width)) &&
           (val_start >= 1) && (val_start <= val_limit) &&
           (64'(val_limit) < (64'd1 << r_width));
  endfunction

endpackage

// File: rtl/dms_operand_buffer.sv
// Local copy of one group's operands: one write port, one combinational read port.
module dms_operand_buffer #(
  parameter int GROUP_SIZE = 4,
  parameter int D_WIDTH    = 8,
  parameter int IW         = 2
) (
  input  logic               Clk,
  input  logic               we,
  input  logic [IW-1:0]      widx,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [IW-1:0]      ridx,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [GROUP_SIZE];

  // NOTE: the bank has no reset; every entry is rewritten before the search reads it.
  always_ff @(posedge Clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/divisor_match_search.sv
// Per group, finds the smallest candidate that at least THRESHOLD buffered operands divide.
module divisor_match_search
  import dms_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int A_WIDTH    = 8,
  parameter int R_WIDTH    = 20,
  parameter int GROUP_SIZE = 4,
  parameter int THRESHOLD  = 3,
  parameter int GROUPS     = 64,
  parameter int VAL_START  = 1,
  parameter int VAL_LIMIT  = 970200
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  input  logic [D_WIDTH-1:0] Data,
  output logic [A_WIDTH-1:0] Addr,
  output logic               En,
  output logic               Rw,
  output logic               Busy,
  output logic               Done,
  output logic               Found,
  output logic [R_WIDTH-1:0] Result
);

  localparam int JW = idx_w(GROUP_SIZE);
  localparam int GW = idx_w(GROUPS);
  localparam int CW = cnt_w(GROUP_SIZE);

  if (!params_ok(GROUP_SIZE, THRESHOLD, GROUPS, A_WIDTH, R_WIDTH, VAL_START, VAL_LIMIT))
  begin : g_bad_params
    $error("divisor_match_search: illegal parameter combination");
  end

  state_t             state, state_n;
  logic [GW-1:0]      g, g_n;
  logic [JW-1:0]      j, j_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [R_WIDTH-1:0] val, val_n;
  logic               found_q, found_n;
  logic [R_WIDTH-1:0] result_q, result_n;
  logic               buf_we;

  logic [D_WIDTH-1:0] opnd;
  logic [D_WIDTH-1:0] divisor;
  logic [R_WIDTH-1:0] remainder;
  logic               hit;
  logic [CW-1:0]      c_next;
  logic               cand_pass;
  logic               cand_fail;
  logic               last_j;
  logic               last_g;

  dms_operand_buffer #(
    .GROUP_SIZE(GROUP_SIZE),
    .D_WIDTH   (D_WIDTH),
    .IW        (JW)
  ) u_buf (
    .Clk  (Clk),
    .we   (buf_we),
    .widx (j),
    .wdata(Data),
    .ridx (j),
    .rdata(opnd)
  );

  // A zero operand is swapped for 1 so the divider never sees zero; hit masks it out.
  assign divisor   = (opnd == '0) ? D_WIDTH'(1) : opnd;
  assign remainder = val % R_WIDTH'(divisor);
  assign hit       = (opnd != '0) && (remainder == '0);
  assign c_next    = cnt + CW'(hit);

  // Fail as soon as the remaining operands can no longer reach the threshold.
  assign cand_pass = int'(c_next) >= THRESHOLD;
  assign cand_fail = (int'(c_next) + (GROUP_SIZE - 1 - int'(j))) < THRESHOLD;
  assign last_j    = (j == JW'(GROUP_SIZE - 1));
  assign last_g    = (g == GW'(GROUPS - 1));

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (Rst) begin
      state    <= IDLE;
      g        <= '0;
      j        <= '0;
      cnt      <= '0;
      val      <= '0;
      found_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_n;
      g        <= g_n;
      j        <= j_n;
      cnt      <= cnt_n;
      val      <= val_n;
      found_q  <= found_n;
      result_q <= result_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n  = state;
    g_n      = g;
    j_n      = j;
    cnt_n    = cnt;
    val_n    = val;
    found_n  = found_q;
    result_n = result_q;
    buf_we   = 1'b0;

    case (state)
      IDLE: begin
        g_n = '0;
        j_n = '0;
        if (Go) state_n = RD;
      end
      RD: state_n = CAP;
      CAP: begin
        buf_we = 1'b1;
        if (last_j) begin
          j_n     = '0;
          state_n = INIT;
        end else begin
          j_n     = j + JW'(1);
          state_n = RD;
        end
      end
      INIT: begin
        val_n   = R_WIDTH'(VAL_START);
        j_n     = '0;
        cnt_n   = '0;
        state_n = CHK;
      end
      CHK: begin
        if (cand_pass) begin
          found_n  = 1'b1;
          result_n = val;
          state_n  = EMIT;
        end else if (cand_fail) begin
          if (val == R_WIDTH'(VAL_LIMIT)) begin
            found_n  = 1'b0;
            result_n = R_WIDTH'(VAL_LIMIT);
            state_n  = EMIT;
          end else begin
            val_n = val + R_WIDTH'(1);
            j_n   = '0;
            cnt_n = '0;
          end
        end else begin
          j_n   = j + JW'(1);
          cnt_n = c_next;
        end
      end
      EMIT: begin
        if (last_g) begin
          state_n = IDLE;
        end else begin
          g_n     = g + GW'(1);
          j_n     = '0;
          state_n = RD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign Addr   = A_WIDTH'(g) * A_WIDTH'(GROUP_SIZE) + A_WIDTH'(j);
  assign En     = (state == RD);
  assign Rw     = 1'b0;
  assign Busy   = (state != IDLE);
  assign Done   = (state == EMIT);
  assign Found  = found_q;
  assign Result = result_q;

endmodule
